// File: rtl/freq_meter_bcd.sv
// Gated frequency meter: counts synchronised edges of `in` over a fixed window of
// GATE_CYCLES clocks in a cascaded BCD counter and latches the result with a valid strobe.
module freq_meter_bcd #(
  parameter int GATE_CYCLES = 10,
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in,
  input  logic                  enable,
  output logic [4*DIGITS-1:0]   out,
  output logic                  valid,
  output logic                  overflow
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam int PW = $clog2(SYNC_STAGES + 2);
  localparam logic [GW-1:0]       GATE_LAST  = GW'(GATE_CYCLES - 1);
  localparam logic [PW-1:0]       PRIME_DONE = PW'(SYNC_STAGES + 1);
  localparam logic [4*DIGITS-1:0] ALL_NINES  = {DIGITS{4'h9}};

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic [PW-1:0]          r_prime;
  logic [GW-1:0]          r_gate;
  logic [4*DIGITS-1:0]    r_bcd;
  logic                   r_ovf;

  logic                   w_sig;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_edge;
  logic                   w_event;
  logic                   w_terminal;
  logic                   w_ripple;
  logic                   w_ovf_win;
  logic [4*DIGITS-1:0]    w_bcd_next;

  assign w_sig  = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sig & ~r_hist;
  assign w_fall = ~w_sig & r_hist;
  assign w_edge = (EDGE_MODE == 0) ? w_rise :
                  (EDGE_MODE == 1) ? w_fall : (w_rise | w_fall);
  // Edges are ignored until the synchroniser and history flop hold real samples.
  assign w_event    = (r_prime == PRIME_DONE) & w_edge;
  assign w_terminal = (r_gate == GATE_LAST);
  assign w_ovf_win  = r_ovf | w_ripple;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_hist  <= 1'b0;
      r_prime <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in};
      r_hist <= w_sig;
      if (r_prime != PRIME_DONE) r_prime <= r_prime + 1'b1;
    end
  end

  // Carry ripples through all digits in one cycle; w_ripple ends as the top carry-out.
  always_comb begin
    w_bcd_next = r_bcd;
    w_ripple   = w_event;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_ripple) begin
        w_bcd_next[4*i +: 4] = (r_bcd[4*i +: 4] == 4'd9) ? 4'd0 : r_bcd[4*i +: 4] + 4'd1;
      end
      w_ripple = w_ripple & (r_bcd[4*i +: 4] == 4'd9);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gate   <= '0;
      r_bcd    <= '0;
      r_ovf    <= 1'b0;
      out      <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else if (!enable) begin
      r_gate <= '0;
      r_bcd  <= '0;
      r_ovf  <= 1'b0;
      valid  <= 1'b0;
    end else if (w_terminal) begin
      r_gate   <= '0;
      r_bcd    <= '0;
      r_ovf    <= 1'b0;
      out      <= w_ovf_win ? ALL_NINES : w_bcd_next;
      overflow <= w_ovf_win;
      valid    <= 1'b1;
    end else begin
      r_gate <= r_gate + 1'b1;
      r_bcd  <= w_bcd_next;
      r_ovf  <= w_ovf_win;
      valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_freq_meter_bcd.sv
// Bench for freq_meter_bcd: four instances with different parameters, a per-window
// scoreboard for the main instance and hand sequences for abort and boundary cases.
module tb_freq_meter_bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en_a, en_o, in_a, in_t, in_d;
  logic [15:0] out_a, out_b, out_c;
  logic [7:0]  out_d;
  logic val_a, val_b, val_c, val_d;
  logic ovf_a, ovf_b, ovf_c, ovf_d;

  freq_meter_bcd #(.GATE_CYCLES(100), .DIGITS(4), .SYNC_STAGES(2), .EDGE_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .enable(en_a),
    .out(out_a), .valid(val_a), .overflow(ovf_a));

  freq_meter_bcd #(.GATE_CYCLES(1000), .DIGITS(4), .SYNC_STAGES(2), .EDGE_MODE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in(in_t), .enable(en_o),
    .out(out_b), .valid(val_b), .overflow(ovf_b));

  freq_meter_bcd #(.GATE_CYCLES(1000), .DIGITS(4), .SYNC_STAGES(2), .EDGE_MODE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in(in_t), .enable(en_o),
    .out(out_c), .valid(val_c), .overflow(ovf_c));

  freq_meter_bcd #(.GATE_CYCLES(150), .DIGITS(2), .SYNC_STAGES(2), .EDGE_MODE(2)) dut_d (
    .clk(clk), .rst_n(rst_n), .in(in_d), .enable(en_o),
    .out(out_d), .valid(val_d), .overflow(ovf_d));

  typedef struct {
    int          half;
    logic [15:0] exp_out;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [15:0] out;
    logic        ovf;
    bit          chk;
  } sb_t;

  vec_t vecs[6];
  sb_t  sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int a_half   = 0;
  int a_ph     = 0;
  int b_win    = 0;
  int c_win    = 0;
  int d_win    = 0;
  bit tog_t    = 0;
  bit tog_d    = 0;
  bit a_seen   = 0;
  bit a_prev   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: observe all outputs at the falling edge, then drive the next inputs.
  task automatic step();
    sb_t e;
    @(negedge clk);
    cyc++;
    a_seen = 0;
    if (val_a) begin
      a_seen = 1;
      chk("a_valid_width", a_prev, 0);
      chk("a_sb_pending", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        if (e.chk) begin
          chk("a_out", out_a, e.out);
          chk("a_ovf", ovf_a, e.ovf);
        end
      end
    end
    a_prev = val_a;
    if (val_b) begin
      b_win++;
      chk("b_valid_time", cyc, 1000 * b_win);
      if (b_win == 2) begin
        chk("b_out_carry", out_b, 16'h1000);
        chk("b_ovf", ovf_b, 0);
      end
    end
    if (val_c) begin
      c_win++;
      chk("c_valid_time", cyc, 1000 * c_win);
      if (c_win == 2) begin
        chk("c_out_fall", out_c, 16'h0500);
        chk("c_ovf", ovf_c, 0);
      end
    end
    if (val_d) begin
      d_win++;
      chk("d_valid_time", cyc, 150 * d_win);
      if (d_win == 2) begin
        chk("d_out_sat", out_d, 8'h99);
        chk("d_ovf_set", ovf_d, 1);
      end
      if (d_win == 3) begin
        chk("d_out_quiet", out_d, 8'h00);
        chk("d_ovf_clear", ovf_d, 0);
      end
    end
    if (a_half != 0) begin
      a_ph++;
      if (a_ph >= a_half) begin
        a_ph = 0;
        in_a = ~in_a;
      end
    end
    if (tog_t) in_t = ~in_t;
    if (cyc == 280) tog_d = 0;
    if (tog_d) in_d = ~in_d;
  endtask

  task automatic wait_a_valid(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!a_seen && n < budget);
    if (!a_seen) chk("a_valid_timeout", a_seen, 1);
  endtask

  initial begin
    int n;
    vecs[0] = '{2,  16'h0025, 1'b0};
    vecs[1] = '{1,  16'h0050, 1'b0};
    vecs[2] = '{25, 16'h0002, 1'b0};
    vecs[3] = '{0,  16'h0000, 1'b0};
    vecs[4] = '{50, 16'h0001, 1'b0};
    vecs[5] = '{5,  16'h0010, 1'b0};

    rst_n = 1'b0; en_a = 1'b0; en_o = 1'b0;
    in_a = 1'b0; in_t = 1'b0; in_d = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step();
      in_a = ~in_a; in_t = ~in_t; in_d = ~in_d;
    end
    chk("rst_out_a", out_a, 16'h0000);
    chk("rst_valid_a", val_a, 0);
    chk("rst_ovf_a", ovf_a, 0);
    chk("rst_out_b", out_b, 16'h0000);
    chk("rst_out_d", out_d, 8'h00);
    chk("rst_valid_d", val_d, 0);

    // Release with `in` high: the first window must not count the initial level.
    cyc = 0;
    rst_n = 1'b1; en_a = 1'b1; en_o = 1'b1;
    in_a = 1'b1; in_t = 1'b1; in_d = 1'b1;
    tog_t = 1; tog_d = 1;
    sb_q.push_back('{16'h0000, 1'b0, 1'b1});
    wait_a_valid(150, n);
    chk("a_first_valid_latency", n, 100);

    // Each pattern: one transition window (unchecked) then one steady window.
    foreach (vecs[r]) begin
      a_half = vecs[r].half;
      a_ph   = 0;
      sb_q.push_back('{16'h0000, 1'b0, 1'b0});
      sb_q.push_back('{vecs[r].exp_out, vecs[r].exp_ovf, 1'b1});
      wait_a_valid(150, n);
      wait_a_valid(150, n);
      chk("a_window_period", n, 100);
    end

    // Abort: fast edges early in the window, enable dropped at gate 5 for 3 clocks.
    a_half = 1; a_ph = 0;
    for (int i = 0; i < 5; i++) step();
    en_a = 1'b0; a_half = 0; in_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_out_hold", out_a, 16'h0010);
      chk("abort_no_valid", val_a, 0);
    end
    en_a = 1'b1;
    sb_q.push_back('{16'h0000, 1'b0, 1'b1});
    wait_a_valid(150, n);
    chk("abort_reassert_latency", n, 100);

    // A single rising edge whose event lands in the terminal cycle.
    sb_q.push_back('{16'h0001, 1'b0, 1'b1});
    sb_q.push_back('{16'h0000, 1'b0, 1'b1});
    for (int i = 0; i < 97; i++) step();
    in_a = 1'b1;
    wait_a_valid(150, n);
    chk("boundary_valid_offset", n, 3);
    wait_a_valid(150, n);
    chk("boundary_next_period", n, 100);

    en_a = 1'b0;
    while (cyc < 2010) step();
    chk("b_windows", b_win, 2);
    chk("c_windows", c_win, 2);
    chk("d_windows_seen", 32'(d_win >= 3), 1);
    chk("a_sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
